tt_um_vote_supervisor: RTL and testbench

TT_UM_VOTE_SUPERVISOR -- requirements
Module: tt_um_vote_supervisor

---
 rtl/tt_um_vote_supervisor.sv | 153 +++++++++++++++
 tb/tb_tt_um_vote_supervisor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_vote_supervisor.sv
// Vote supervisor: OK/SUSPECT/TRIPPED/RECOVER FSM with a fail/pass streak counter; optional peak-fail register under VOTE_SUP_PEAK_EN.
// Latency: one clk edge from accepted sample to registered uo_out. No backpressure: samples are taken whenever ena & sample_valid.
module tt_um_vote_supervisor (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_SUSPECT  = 2'b01,
        ST_TRIPPED  = 2'b10,
        ST_RECOVER  = 2'b11
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] streak, streak_nxt;
    logic       alarm, alarm_nxt;
    logic       trip_pulse, trip_pulse_nxt;
    logic       peak_clr;
    logic [3:0] peak_fails;

    logic       accept, fail, pass, ack;
    logic [3:0] count_fails, trip_thr, rec_thr, streak_sat;
    logic [4:0] streak_inc;

    assign accept      = ena & ui_in[5];
    assign fail        = accept & ui_in[0];
    assign pass        = accept & ~ui_in[0];
    assign ack         = ena & ui_in[6];
    assign count_fails = ui_in[4:1];

    // A programmed threshold of zero behaves as one.
    assign trip_thr   = (uio_in[3:0] == 4'd0) ? 4'd1 : uio_in[3:0];
    assign rec_thr    = (uio_in[7:4] == 4'd0) ? 4'd1 : uio_in[7:4];
    assign streak_inc = {1'b0, streak} + 5'd1;
    assign streak_sat = (streak == 4'hF) ? 4'hF : streak_inc[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_OK;
            streak <= 4'd0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        case (state)
            ST_OK: begin
                if (fail) begin
                    if (trip_thr == 4'd1) begin
                        state_nxt  = ST_TRIPPED;
                        streak_nxt = 4'd0;
                    end else begin
                        state_nxt  = ST_SUSPECT;
                        streak_nxt = 4'd1;
                    end
                end else if (pass) begin
                    streak_nxt = 4'd0;
                end
            end
            ST_SUSPECT: begin
                if (fail) begin
                    if (streak_inc >= {1'b0, trip_thr}) begin
                        state_nxt  = ST_TRIPPED;
                        streak_nxt = 4'd0;
                    end else begin
                        streak_nxt = streak_sat;
                    end
                end else if (pass) begin
                    state_nxt  = ST_OK;
                    streak_nxt = 4'd0;
                end
            end
            ST_TRIPPED: begin
                if (pass) begin
                    if (streak_inc >= {1'b0, rec_thr}) begin
                        state_nxt  = ST_RECOVER;
                        streak_nxt = 4'd0;
                    end else begin
                        streak_nxt = streak_sat;
                    end
                end else if (fail) begin
                    streak_nxt = 4'd0;
                end
            end
            ST_RECOVER: begin
                // A fail on the ack edge takes priority over the ack.
                if (fail) begin
                    state_nxt  = ST_TRIPPED;
                    streak_nxt = 4'd0;
                end else if (ack) begin
                    state_nxt  = ST_OK;
                    streak_nxt = 4'd0;
                end
            end
            default: begin
                state_nxt  = ST_OK;
                streak_nxt = 4'd0;
            end
        endcase
    end

    always_comb begin
        alarm_nxt      = (state_nxt == ST_TRIPPED) || (state_nxt == ST_RECOVER);
        trip_pulse_nxt = (state_nxt == ST_TRIPPED) && (state != ST_TRIPPED);
        peak_clr       = (state == ST_RECOVER) && (state_nxt == ST_OK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm      <= 1'b0;
            trip_pulse <= 1'b0;
        end else begin
            alarm      <= alarm_nxt;
            trip_pulse <= trip_pulse_nxt;
        end
    end

`ifdef VOTE_SUP_PEAK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_fails <= 4'd0;
        end else if (peak_clr) begin
            peak_fails <= 4'd0;
        end else if (accept && (count_fails > peak_fails)) begin
            peak_fails <= count_fails;
        end
    end

    logic unused;
    assign unused = &{1'b0, ui_in[7]};
`else
    assign peak_fails = 4'd0;

    logic unused;
    assign unused = &{1'b0, ui_in[7], count_fails, peak_clr};
`endif

    assign uo_out  = {trip_pulse, peak_fails, state, alarm};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_vote_supervisor.sv
// Bench for tt_um_vote_supervisor: directed scenarios plus random traffic scored against an integer reference model.
module tb_tt_um_vote_supervisor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    tt_um_vote_supervisor dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_step  = 0;
    logic [23:0] exp_q[$];

    // Reference model: state as 0=OK 1=SUSPECT 2=TRIPPED 3=RECOVER.
    int m_state = 0;
    int m_streak = 0;
    int m_peak = 0;
    bit m_pulse = 0;

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_streak = 0; m_peak = 0; m_pulse = 0;
    endtask

    function automatic logic [7:0] model_out();
        int pk;
        pk = 0;
`ifdef VOTE_SUP_PEAK_EN
        pk = m_peak;
`endif
        return {m_pulse, pk[3:0], m_state[1:0], (m_state >= 2) ? 1'b1 : 1'b0};
    endfunction

    task automatic model_step(input bit en, input bit vld, input bit res, input bit ak,
                              input int cnt, input int trip, input int rec);
        bit acc, f, p, a, cleared;
        int t, r, prev;
        acc = en && vld; f = acc && res; p = acc && !res; a = en && ak;
        t = (trip == 0) ? 1 : trip;
        r = (rec == 0) ? 1 : rec;
        prev = m_state;
        cleared = 0;
        case (m_state)
            0: if (f) begin
                   if (t == 1) begin m_state = 2; m_streak = 0; end
                   else begin m_state = 1; m_streak = 1; end
               end else if (p) m_streak = 0;
            1: if (f) begin
                   if (m_streak + 1 >= t) begin m_state = 2; m_streak = 0; end
                   else m_streak = (m_streak + 1 > 15) ? 15 : m_streak + 1;
               end else if (p) begin m_state = 0; m_streak = 0; end
            2: if (p) begin
                   if (m_streak + 1 >= r) begin m_state = 3; m_streak = 0; end
                   else m_streak = (m_streak + 1 > 15) ? 15 : m_streak + 1;
               end else if (f) m_streak = 0;
            default: if (f) begin m_state = 2; m_streak = 0; end
                     else if (a) begin m_state = 0; m_streak = 0; cleared = 1; end
        endcase
        if (acc && cnt > m_peak) m_peak = cnt;
        if (cleared) m_peak = 0;
        m_pulse = (m_state == 2) && (prev != 2);
    endtask

    // Drive one sample at the falling edge, log the expectation, return just after the rising edge.
    task automatic step(input bit en, input bit vld, input bit res, input bit ak,
                        input int cnt, input int trip, input int rec);
        logic [3:0] c4, t4, r4;
        @(negedge clk);
        c4 = cnt[3:0]; t4 = trip[3:0]; r4 = rec[3:0];
        ena    = en;
        ui_in  = {1'($urandom_range(0, 1)), ak, vld, c4, res};
        uio_in = {r4, t4};
        model_step(en, vld, res, ak, cnt, trip, rec);
        exp_q.push_back({16'h0000, model_out()});
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        logic [23:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_step++;
            n_tests++;
            if ({uio_oe, uio_out, uo_out} != e) begin
                n_fail++;
                $display("FAIL scoreboard step %0d: got uo=%02h uio_out=%02h uio_oe=%02h, expected uo=%02h uio=00",
                         n_step, uo_out, uio_out, uio_oe, e[7:0]);
            end
        end
    end

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        ena = 1'b0;
        model_reset();
        #1;
        chk("async reset uo_out", int'(uo_out), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_pk;
        #3;
        chk("reset uo_out", int'(uo_out), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Three consecutive fails with threshold 3.
        chk("trip seq state0", int'(uo_out[2:1]), 0);
        step(1, 1, 1, 0, 1, 3, 1);
        chk("trip seq state1", int'(uo_out[2:1]), 1);
        step(1, 1, 1, 0, 1, 3, 1);
        chk("trip seq state2", int'(uo_out[2:1]), 1);
        chk("trip seq alarm2", int'(uo_out[0]), 0);
        step(1, 1, 1, 0, 1, 3, 1);
        chk("trip seq state3", int'(uo_out[2:1]), 2);
        chk("trip seq alarm3", int'(uo_out[0]), 1);
        chk("trip seq pulse3", int'(uo_out[7]), 1);
        step(1, 1, 1, 0, 1, 3, 5);
        chk("trip seq pulse gone", int'(uo_out[7]), 0);

        // fail,fail,pass,fail never trips; two more fails show the streak restarted at 1.
        do_reset();
        step(1, 1, 1, 0, 0, 3, 1);
        step(1, 1, 1, 0, 0, 3, 1);
        step(1, 1, 0, 0, 0, 3, 1);
        chk("interrupted pass state", int'(uo_out[2:1]), 0);
        step(1, 1, 1, 0, 0, 3, 1);
        chk("interrupted end state", int'(uo_out[2:1]), 1);
        step(1, 1, 1, 0, 0, 3, 1);
        chk("interrupted streak2", int'(uo_out[2:1]), 1);
        step(1, 1, 1, 0, 0, 3, 1);
        chk("interrupted streak3 trips", int'(uo_out[2:1]), 2);

        // Recovery with recover_n=2, then ack (ack alone, no sample).
        step(1, 1, 0, 1, 0, 3, 2);
        chk("recover pass1 state", int'(uo_out[2:1]), 2);
        step(1, 1, 0, 0, 0, 3, 2);
        chk("recover pass2 state", int'(uo_out[2:1]), 3);
        chk("recover pass2 alarm", int'(uo_out[0]), 1);
        step(1, 0, 0, 1, 0, 3, 2);
        chk("ack state", int'(uo_out[2:1]), 0);
        chk("ack alarm", int'(uo_out[0]), 0);

        // Ack and fail together in RECOVER.
        step(1, 1, 1, 0, 0, 1, 2);
        step(1, 1, 0, 0, 0, 1, 2);
        step(1, 1, 0, 0, 0, 1, 2);
        chk("recover again", int'(uo_out[2:1]), 3);
        step(1, 1, 1, 1, 0, 1, 2);
        chk("ack+fail state", int'(uo_out[2:1]), 2);
        chk("ack+fail pulse", int'(uo_out[7]), 1);

        // trip_n=0 behaves as 1; peak capture.
        do_reset();
        step(1, 1, 1, 0, 9, 0, 0);
        chk("trip0 alarm", int'(uo_out[0]), 1);
        exp_pk = 0;
`ifdef VOTE_SUP_PEAK_EN
        exp_pk = 9;
`endif
        chk("trip0 peak", int'(uo_out[6:3]), exp_pk);

        // Async reset while TRIPPED, then ena=0 blocks a fail.
        do_reset();
        step(0, 1, 1, 1, 7, 1, 1);
        chk("ena0 state", int'(uo_out[2:1]), 0);
        chk("ena0 uo_out", int'(uo_out), 0);

        // Random traffic with small thresholds to visit every state.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15),
                 $urandom_range(0, 4), $urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        @(posedge clk);
        #3;
        chk("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
